mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 147 ++++++++++++++
 tb/tb_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Fixed-latency single-port memory responder with protocol error flags.
// A request sampled at an IDLE edge completes LATENCY edges later, counting the accepting edge.
module mem_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        err_rw,
  output logic        err_unstable,
  output logic        err_range
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // state | meaning
  // IDLE  | waiting for exactly one of mem_read/mem_write
  // WAIT  | latency countdown, request watched for stability
  // RESP  | one-cycle completion, mem_resp high
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        op_wr_q, op_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        resp_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_rw_q, err_rw_d;
  logic        err_unstable_q, err_unstable_d;
  logic        err_range_q, err_range_d;

  logic          go_resp;
  logic          go_wr;
  logic [AW-1:0] go_idx;
  logic [3:0]    go_be;
  logic [31:0]   go_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_d        = state_q;
    op_wr_d        = op_wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    cnt_d          = cnt_q;
    err_rw_d       = err_rw_q;
    err_unstable_d = err_unstable_q;
    err_range_d    = err_range_q;
    go_resp        = 1'b0;
    go_wr          = op_wr_q;
    go_idx         = addr_q[AW+1:2];
    go_be          = be_q;
    go_wdata       = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_read && mem_write) begin
          err_rw_d = 1'b1;
        end else if (mem_read || mem_write) begin
          op_wr_d = mem_write;
          addr_d  = mem_address;
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          cnt_d   = 4'(LATENCY - 1);
          if ({1'b0, mem_address[31:2]} >= 31'(DEPTH_WORDS)) err_range_d = 1'b1;
          if (LATENCY == 1) begin
            // no WAIT cycle: complete straight from the live request
            state_d  = RESP;
            go_resp  = 1'b1;
            go_wr    = mem_write;
            go_idx   = mem_address[AW+1:2];
            go_be    = mem_byte_enable;
            go_wdata = mem_wdata;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if ((mem_read == op_wr_q) || (mem_write != op_wr_q) || (mem_address != addr_q))
          err_unstable_d = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdata_d = rdata_q;
    if (go_resp && !go_wr) rdata_d = mem[go_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      op_wr_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      cnt_q          <= '0;
      resp_q         <= 1'b0;
      rdata_q        <= '0;
      err_rw_q       <= 1'b0;
      err_unstable_q <= 1'b0;
      err_range_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_wr_q        <= op_wr_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      cnt_q          <= cnt_d;
      resp_q         <= go_resp;
      rdata_q        <= rdata_d;
      err_rw_q       <= err_rw_d;
      err_unstable_q <= err_unstable_d;
      err_range_q    <= err_range_d;
    end
  end

  // contents survive reset; the rst gate keeps a held request from writing during it
  always_ff @(posedge clk) begin
    if (rst && go_resp && go_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (go_be[i]) mem[go_idx][8*i +: 8] <= go_wdata[8*i +: 8];
      end
    end
  end

  assign mem_resp     = resp_q;
  assign mem_rdata    = rdata_q;
  assign err_rw       = err_rw_q;
  assign err_unstable = err_unstable_q;
  assign err_range    = err_range_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY 2, 4 and 1 (instances 0, 1, 2).
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       rd, wr;
  logic [2:0][3:0]  be;
  logic [2:0][31:0] addr, wd;
  logic [2:0]       resp, e_rw, e_un, e_rg;
  logic [2:0][31:0] rdata;

  mem_responder #(.LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]), .mem_byte_enable(be[0]),
    .mem_address(addr[0]), .mem_wdata(wd[0]), .mem_resp(resp[0]), .mem_rdata(rdata[0]),
    .err_rw(e_rw[0]), .err_unstable(e_un[0]), .err_range(e_rg[0]));

  mem_responder #(.LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]), .mem_byte_enable(be[1]),
    .mem_address(addr[1]), .mem_wdata(wd[1]), .mem_resp(resp[1]), .mem_rdata(rdata[1]),
    .err_rw(e_rw[1]), .err_unstable(e_un[1]), .err_range(e_rg[1]));

  mem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .mem_read(rd[2]), .mem_write(wr[2]), .mem_byte_enable(be[2]),
    .mem_address(addr[2]), .mem_wdata(wd[2]), .mem_resp(resp[2]), .mem_rdata(rdata[2]),
    .err_rw(e_rw[2]), .err_unstable(e_un[2]), .err_range(e_rg[2]));

  int n_checks = 0;
  int n_err    = 0;
  int unsigned cyc = 0;
  int pulses2 = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (resp[2]) pulses2 <= pulses2 + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic txn(input int k, input logic is_wr, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input int lat, output logic [31:0] rdat,
                     output int unsigned t);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    rd[k] = !is_wr; wr[k] = is_wr; addr[k] = a; be[k] = b; wd[k] = d;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (resp[k]) seen = 1'b1;
    end
    chk("resp_seen", {31'd0, seen}, 32'd1);
    chk("latency", 32'(n), 32'(lat));
    rdat = rdata[k];
    t = cyc;
    rd[k] = 1'b0; wr[k] = 1'b0;
    @(negedge clk);
    chk("resp_one_cycle", {31'd0, resp[k]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int unsigned t, prev_t;
    int cnt, n, p0;
    logic seen;

    rst = 1'b0; rd = '0; wr = '0; be = '0; addr = '0; wd = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_resp", {31'd0, resp[k]}, 32'd0);
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_errs", {29'd0, e_rw[k], e_un[k], e_rg[k]}, 32'd0);
    end

    // first edge after reset release accepts (latency still 2)
    rst = 1'b1;
    txn(0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 2, r, t);
    txn(0, 1'b0, 32'h40, 4'h0, 32'h0, 2, r, t);
    chk("rd_deadbeef", r, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h40, 4'b0101, 32'h11223344, 2, r, t);
    txn(0, 1'b0, 32'h40, 4'h0, 32'h0, 2, r, t);
    chk("rd_be0101", r, 32'hDE22BE44);
    txn(0, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, 2, r, t);
    chk("rdata_hold_on_write", r, 32'hDE22BE44);
    txn(0, 1'b0, 32'h40, 4'h0, 32'h0, 2, r, t);
    chk("rd_after_be0", r, 32'hDE22BE44);

    chk("range_clear", {31'd0, e_rg[0]}, 32'd0);
    txn(0, 1'b1, 32'h1010, 4'hF, 32'hCAFEF00D, 2, r, t);
    chk("range_set", {31'd0, e_rg[0]}, 32'd1);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 2, r, t);
    chk("range_wrap", r, 32'hCAFEF00D);
    chk("no_rw_err", {31'd0, e_rw[0]}, 32'd0);
    chk("no_unstable_err", {31'd0, e_un[0]}, 32'd0);

    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h40;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp[0]) cnt++;
    end
    chk("rw_no_resp", 32'(cnt), 32'd0);
    chk("rw_err", {31'd0, e_rw[0]}, 32'd1);
    rd[0] = 1'b0; wr[0] = 1'b0;
    @(negedge clk);
    txn(0, 1'b0, 32'h40, 4'h0, 32'h0, 2, r, t);
    chk("rd_after_rw", r, 32'hDE22BE44);
    chk("rw_err_sticky", {31'd0, e_rw[0]}, 32'd1);

    txn(1, 1'b1, 32'h40, 4'hF, 32'h0BADC0DE, 4, r, t);
    txn(1, 1'b1, 32'h44, 4'hF, 32'h44444444, 4, r, t);
    chk("l4_unstable_clear", {31'd0, e_un[1]}, 32'd0);
    rd[1] = 1'b1; addr[1] = 32'h40;
    @(negedge clk);
    addr[1] = 32'h44;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (resp[1]) seen = 1'b1;
    end
    chk("l4_resp_seen", {31'd0, seen}, 32'd1);
    chk("l4_latency", 32'(n), 32'd4);
    chk("l4_latched_addr_data", rdata[1], 32'h0BADC0DE);
    chk("l4_unstable_set", {31'd0, e_un[1]}, 32'd1);
    rd[1] = 1'b0;
    @(negedge clk);
    txn(1, 1'b0, 32'h44, 4'h0, 32'h0, 4, r, t);
    chk("l4_rd_44", r, 32'h44444444);
    chk("l4_unstable_sticky", {31'd0, e_un[1]}, 32'd1);

    // abort a write in WAIT with reset; memory must keep the old word
    txn(0, 1'b1, 32'h80, 4'hF, 32'h12345678, 2, r, t);
    wr[0] = 1'b1; addr[0] = 32'h80; be[0] = 4'hF; wd[0] = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b0;
    wr[0] = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp[0]) cnt++;
    end
    chk("abort_no_resp", 32'(cnt), 32'd0);
    chk("abort_rdata_zero", rdata[0], 32'd0);
    chk("abort_errs_clear", {29'd0, e_rw[0], e_un[0], e_rg[0]}, 32'd0);
    chk("abort_l4_unstable_clear", {31'd0, e_un[1]}, 32'd0);
    rst = 1'b1;
    txn(0, 1'b0, 32'h80, 4'h0, 32'h0, 2, r, t);
    chk("abort_mem_kept", r, 32'h12345678);

    txn(2, 1'b1, 32'h8, 4'hF, 32'h5A5A5A5A, 1, r, t);
    txn(2, 1'b0, 32'h8, 4'h0, 32'h0, 1, r, t);
    chk("l1_rd_after_wr", r, 32'h5A5A5A5A);
    p0 = pulses2;
    prev_t = 0;
    for (int i = 0; i < 100; i++) begin
      txn(2, 1'b0, 32'(i * 4), 4'h0, 32'h0, 1, r, t);
      if (i > 0) chk("l1_spacing", t - prev_t, 32'd2);
      prev_t = t;
    end
    chk("l1_pulse_count", 32'(pulses2 - p0), 32'd100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
